// File: rtl/lp805x_sfrbus_pipe_if.sv
// SFR bus bundle between the lp805x core, the request pipeline and the peripheral return channels.
// The pipeline uses the slave modport; the core/peripheral side uses master.
interface lp805x_sfrbus_pipe_if #(
    parameter int unsigned NCH = 4
);
    logic             load;
    logic             flush;
    logic             clr_err;
    logic [7:0]       wr_addr;
    logic [7:0]       rd_addr;
    logic [7:0]       data_in;
    logic             wr;
    logic             rd;
    logic             bit_in;
    logic             wr_bit;
    logic             rd_bit;
    logic [28:0]      sfr_req;
    logic [8*NCH-1:0] ch_data;
    logic [NCH-1:0]   ch_bit;
    logic [NCH-1:0]   ch_ack;
    logic [7:0]       rsp_data;
    logic             rsp_bit;
    logic             rsp_valid;
    logic             rsp_miss;
    logic             collision;

    modport master (
        output load, flush, clr_err, wr_addr, rd_addr, data_in, wr, rd, bit_in, wr_bit, rd_bit,
        output ch_data, ch_bit, ch_ack,
        input  sfr_req, rsp_data, rsp_bit, rsp_valid, rsp_miss, collision
    );

    modport slave (
        input  load, flush, clr_err, wr_addr, rd_addr, data_in, wr, rd, bit_in, wr_bit, rd_bit,
        input  ch_data, ch_bit, ch_ack,
        output sfr_req, rsp_data, rsp_bit, rsp_valid, rsp_miss, collision
    );
endinterface

// File: rtl/lp805x_sfrbus_pipe.sv
// SFR bus pipeline: DEPTH load-gated request stages plus a registered, priority-merged response.
// Define LP805X_SFRBUS_COLLISION_EN to build the sticky multi-ack collision flag.
module lp805x_sfrbus_pipe #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned NCH   = 4
) (
    input logic                 clk,
    input logic                 rst,
    lp805x_sfrbus_pipe_if.slave bus
);
    localparam int unsigned W = 29;
    // Bundle layout: {wr_addr, rd_addr, data_in, wr, rd, bit_in, wr_bit, rd_bit}
    localparam logic [W-1:0] STROBE_MASK = 29'h0000_001B;

    logic [W-1:0] stage_q [DEPTH];
    logic [W-1:0] stage_d [DEPTH];
    logic [W-1:0] req_in;
    logic [W-1:0] keep;
    logic [W-1:0] req_out;

    assign req_in = {bus.wr_addr, bus.rd_addr, bus.data_in,
                     bus.wr, bus.rd, bus.bit_in, bus.wr_bit, bus.rd_bit};
    assign keep   = bus.flush ? ~STROBE_MASK : '1;

    always_comb begin
        stage_d[0] = (bus.load ? req_in : stage_q[0]) & keep;
        for (int i = 1; i < int'(DEPTH); i++) begin
            stage_d[i] = (bus.load ? stage_q[i-1] : stage_q[i]) & keep;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign req_out     = stage_q[DEPTH-1];
    assign bus.sfr_req = req_out;

    // Capture looks at the registered output stage, so a same-cycle flush cannot cancel it.
    logic       capture;
    logic       sel_hit;
    logic [7:0] sel_data;
    logic       sel_bit;

    assign capture = bus.load & (req_out[3] | req_out[0]);

    always_comb begin
        sel_hit  = 1'b0;
        sel_data = 8'hFF;
        sel_bit  = 1'b1;
        for (int k = int'(NCH) - 1; k >= 0; k--) begin
            if (bus.ch_ack[k]) begin
                sel_hit  = 1'b1;
                sel_data = bus.ch_data[8*k +: 8];
                sel_bit  = bus.ch_bit[k];
            end
        end
    end

    logic [7:0] rsp_data_q;
    logic       rsp_bit_q;
    logic       rsp_valid_q;
    logic       rsp_miss_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_data_q  <= 8'h00;
            rsp_bit_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_miss_q  <= 1'b0;
        end else begin
            rsp_valid_q <= capture & sel_hit;
            rsp_miss_q  <= capture & ~sel_hit;
            if (capture) begin
                rsp_data_q <= sel_data;
                rsp_bit_q  <= sel_bit;
            end
        end
    end

    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_bit   = rsp_bit_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_miss  = rsp_miss_q;

`ifdef LP805X_SFRBUS_COLLISION_EN
    logic multi_ack;
    logic collision_q;

    always_comb begin
        logic seen;
        seen      = 1'b0;
        multi_ack = 1'b0;
        for (int k = 0; k < int'(NCH); k++) begin
            if (bus.ch_ack[k]) begin
                if (seen) multi_ack = 1'b1;
                seen = 1'b1;
            end
        end
    end

    // Set has priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            collision_q <= 1'b0;
        end else if (capture && multi_ack) begin
            collision_q <= 1'b1;
        end else if (bus.clr_err) begin
            collision_q <= 1'b0;
        end
    end

    assign bus.collision = collision_q;
`else
    logic unused_clr_err;
    assign unused_clr_err = bus.clr_err;
    assign bus.collision  = 1'b0;
`endif
endmodule
